// File: rtl/acc_cpu_core_if.sv
// -----------------------------------------------------------------------------
// acc_cpu_core_if
//   Unified program/data memory bus between the accumulator core and memory.
//   A req/ack handshake: the master raises mem_req with mem_we/mem_addr/
//   mem_wdata and holds them stable until the edge on which mem_ack is high.
//   mem_ack may be high in the same cycle mem_req rises (zero wait states).
//
//   mem_req    master -> slave   access request
//   mem_we     master -> slave   1 = write mem_wdata, 0 = read
//   mem_addr   master -> slave   access address (ADDR_W)
//   mem_wdata  master -> slave   store data (DATA_W)
//   mem_rdata  slave  -> master  read data, sampled on the ack edge (DATA_W)
//   mem_ack    slave  -> master  access completes this cycle
// -----------------------------------------------------------------------------
interface acc_cpu_core_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ack
   );
endinterface

// File: rtl/acc_cpu_core.sv
// -----------------------------------------------------------------------------
// acc_cpu_core
//   Single-accumulator CPU core. Fetches and executes instructions from a
//   unified memory over a req/ack bus, keeps Z/N/C/V status flags and stops
//   in a HALT state until reset.
//
//   Instruction word: opcode = instr[DATA_W-1 -: 4], operand A = instr[ADDR_W-1:0]
//   DATA_W must be >= ADDR_W+4 so the two fields do not overlap.
//
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   bus        master modport of acc_cpu_core_if (mem_req/we/addr/wdata/rdata/ack)
//   halted     out  1        core is in HALT
//   pc_dbg     out  ADDR_W   current PC
//   acc_dbg    out  DATA_W   current ACC
//   flags_dbg  out  4        {Z,N,C,V}
// -----------------------------------------------------------------------------
module acc_cpu_core #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic                 clk,
   input  logic                 rst_n,
   acc_cpu_core_if.master       bus,
   output logic                 halted,
   output logic [ADDR_W-1:0]    pc_dbg,
   output logic [DATA_W-1:0]    acc_dbg,
   output logic [3:0]           flags_dbg
);

   localparam int MSB = DATA_W - 1;

   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_AND   = 4'h5;
   localparam logic [3:0] OP_OR    = 4'h6;
   localparam logic [3:0] OP_NOT   = 4'h7;
   localparam logic [3:0] OP_SHR   = 4'h8;
   localparam logic [3:0] OP_SHL   = 4'h9;
   localparam logic [3:0] OP_JMP   = 4'hA;
   localparam logic [3:0] OP_JGEZ  = 4'hB;
   localparam logic [3:0] OP_JZ    = 4'hC;
   localparam logic [3:0] OP_HALT  = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [3:0]        op_q, op_d;       // opcode field of IR
   logic [ADDR_W-1:0] opa_q, opa_d;     // operand field of IR
   logic [3:0]        flags_q, flags_d; // {Z,N,C,V}
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              halted_q, halted_d;

   logic [ADDR_W-1:0] pc_inc_s;
   logic [ADDR_W-1:0] fetch_next_s;
   logic [3:0]        fetch_op_s;
   logic              acked_s;

   // Opcodes 1..6 need a second (data) bus access during EXEC.
   function automatic logic is_mem_op(input logic [3:0] op);
      return (op >= OP_LOAD) && (op <= OP_OR);
   endfunction

   // Conditional/unconditional jump decision using flags as they stand now.
   function automatic logic jump_taken(input logic [3:0] op, input logic [3:0] fl);
      logic taken;
      case (op)
         OP_JMP:  taken = 1'b1;
         OP_JGEZ: taken = ~fl[2];
         OP_JZ:   taken = fl[3];
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

   // ALU: returns {flags, acc} after executing op; ops that do not touch
   // ACC/flags (STORE, jumps, NOP, HALT) return the inputs unchanged.
   function automatic logic [DATA_W+3:0] alu_f(
      input logic [3:0]        op,
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] m,
      input logic [3:0]        fl
   );
      logic [DATA_W-1:0] r;
      logic [DATA_W:0]   w;
      logic              c;
      logic              v;
      logic              upd;
      r   = a;
      w   = {(DATA_W+1){1'b0}};
      c   = fl[1];
      v   = fl[0];
      upd = 1'b1;
      case (op)
         OP_LOAD: begin r = m; v = 1'b0; end
         OP_ADD: begin
            w = {1'b0, a} + {1'b0, m};
            r = w[MSB:0];
            c = w[DATA_W];
            v = (a[MSB] == m[MSB]) && (r[MSB] != a[MSB]);
         end
         OP_SUB: begin
            r = a - m;
            c = (a >= m);              // 1 = no borrow
            v = (a[MSB] != m[MSB]) && (r[MSB] != a[MSB]);
         end
         OP_AND: begin r = a & m; v = 1'b0; end
         OP_OR:  begin r = a | m; v = 1'b0; end
         OP_NOT: begin r = ~a;    v = 1'b0; end
         OP_SHR: begin r = {1'b0, a[MSB:1]}; c = a[0];   v = 1'b0; end
         OP_SHL: begin r = {a[MSB-1:0], 1'b0}; c = a[MSB]; v = 1'b0; end
         default: upd = 1'b0;
      endcase
      if (upd) begin
         return {(r == {DATA_W{1'b0}}), r[MSB], c, v, r};
      end else begin
         return {fl, a};
      end
   endfunction

   // State register and all architectural/bus registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         acc_q    <= {DATA_W{1'b0}};
         op_q     <= 4'h0;
         opa_q    <= {ADDR_W{1'b0}};
         flags_q  <= 4'h0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= {ADDR_W{1'b0}};
         wdata_q  <= {DATA_W{1'b0}};
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         acc_q    <= acc_d;
         op_q     <= op_d;
         opa_q    <= opa_d;
         flags_q  <= flags_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         halted_q <= halted_d;
      end
   end

   // Next-state logic. Bus outputs are registered, so each transition sets up
   // the request for the following state: a fetch that returns a memory op
   // already drives the data access in the first EXEC cycle, which keeps
   // zero-wait execution at two cycles per instruction.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      acc_d        = acc_q;
      op_d         = op_q;
      opa_d        = opa_q;
      flags_d      = flags_q;
      req_d        = req_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      halted_d     = halted_q;
      pc_inc_s     = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      fetch_op_s   = bus.mem_rdata[MSB -: 4];
      acked_s      = req_q & bus.mem_ack;
      fetch_next_s = pc_q;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = pc_q;
         end

         ST_FETCH: begin
            if (acked_s) begin
               op_d    = fetch_op_s;
               opa_d   = bus.mem_rdata[ADDR_W-1:0];
               pc_d    = pc_inc_s;
               state_d = ST_EXEC;
               if (is_mem_op(fetch_op_s)) begin
                  req_d   = 1'b1;
                  we_d    = (fetch_op_s == OP_STORE);
                  addr_d  = bus.mem_rdata[ADDR_W-1:0];
                  wdata_d = acc_q;
               end else begin
                  req_d = 1'b0;
                  we_d  = 1'b0;
               end
            end else begin
               state_d = ST_FETCH;
            end
         end

         ST_EXEC: begin
            if (is_mem_op(op_q)) begin
               if (acked_s) begin
                  {flags_d, acc_d} = alu_f(op_q, acc_q, bus.mem_rdata, flags_q);
                  state_d = ST_FETCH;
                  req_d   = 1'b1;
                  we_d    = 1'b0;
                  addr_d  = pc_q;
               end else begin
                  state_d = ST_EXEC;
               end
            end else if (op_q == OP_HALT) begin
               state_d  = ST_HALT;
               req_d    = 1'b0;
               we_d     = 1'b0;
               halted_d = 1'b1;
            end else begin
               // A taken jump replaces the PC already incremented at fetch.
               if (jump_taken(op_q, flags_q)) begin
                  fetch_next_s = opa_q;
               end else begin
                  fetch_next_s = pc_q;
               end
               {flags_d, acc_d} = alu_f(op_q, acc_q, bus.mem_rdata, flags_q);
               pc_d    = fetch_next_s;
               state_d = ST_FETCH;
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = fetch_next_s;
            end
         end

         ST_HALT: begin
            state_d  = ST_HALT;
            req_d    = 1'b0;
            we_d     = 1'b0;
            halted_d = 1'b1;
         end

         default: begin
            state_d  = ST_IDLE;
            req_d    = 1'b0;
            we_d     = 1'b0;
            halted_d = 1'b0;
         end
      endcase
   end

   assign bus.mem_req   = req_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign halted        = halted_q;
   assign pc_dbg        = pc_q;
   assign acc_dbg       = acc_q;
   assign flags_dbg     = flags_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// -----------------------------------------------------------------------------
// tb_acc_cpu_core
//   Directed bench for acc_cpu_core: a memory model with a programmable number
//   of wait states, short hand-assembled programs and hand-computed results.
// -----------------------------------------------------------------------------
module tb_acc_cpu_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        halted;
   logic [7:0]  pc_dbg;
   logic [15:0] acc_dbg;
   logic [3:0]  flags_dbg;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   acc_cpu_core_if #(.DATA_W(16), .ADDR_W(8)) bus ();

   acc_cpu_core #(.DATA_W(16), .ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .halted    (halted),
      .pc_dbg    (pc_dbg),
      .acc_dbg   (acc_dbg),
      .flags_dbg (flags_dbg)
   );

   // ---------------- memory model with wait states ----------------
   logic [15:0] mem [256];
   logic [7:0]  delay = 8'd0;
   logic [7:0]  wcnt;
   logic [7:0]  rd_log [64];
   int          rd_n;

   assign bus.mem_ack   = bus.mem_req && (wcnt == delay);
   assign bus.mem_rdata = mem[bus.mem_addr];

   // Completes accesses after 'delay' waiting cycles and logs read addresses.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt <= 8'd0;
         rd_n = 0;
      end else if (bus.mem_req && bus.mem_ack) begin
         wcnt <= 8'd0;
         if (bus.mem_we) begin
            mem[bus.mem_addr] = bus.mem_wdata;
         end else if (rd_n < 64) begin
            rd_log[rd_n] = bus.mem_addr;
            rd_n = rd_n + 1;
         end
      end else if (bus.mem_req) begin
         wcnt <= wcnt + 8'd1;
      end else begin
         wcnt <= 8'd0;
      end
   end

   // Request stability monitor: a request not acked must look identical next cycle.
   logic        pend;
   logic [7:0]  s_addr;
   logic        s_we;
   logic [15:0] s_wdata;
   int          hold_viol;
   int          waits;

   always @(negedge clk) begin
      if (!rst_n) begin
         pend      = 1'b0;
         hold_viol = 0;
         waits     = 0;
      end else begin
         if (pend) begin
            waits = waits + 1;
            if (!bus.mem_req || bus.mem_addr !== s_addr || bus.mem_we !== s_we ||
                (s_we && bus.mem_wdata !== s_wdata))
               hold_viol = hold_viol + 1;
         end
         pend    = bus.mem_req && !bus.mem_ack;
         s_addr  = bus.mem_addr;
         s_we    = bus.mem_we;
         s_wdata = bus.mem_wdata;
      end
   end

   // ---------------- helpers ----------------
   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ins(input logic [3:0] op, input logic [7:0] a);
      return {op, 4'h0, a};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
   endtask

   task automatic load_prog1();
      clear_mem();
      mem[8'h00] = ins(4'h1, 8'h10);
      mem[8'h01] = ins(4'h3, 8'h11);
      mem[8'h02] = ins(4'h2, 8'h12);
      mem[8'h03] = ins(4'hF, 8'h00);
      mem[8'h10] = 16'h7FFF;
      mem[8'h11] = 16'h0001;
   endtask

   // Hold reset across two falling edges, release on a falling edge, then
   // step past the IDLE->FETCH edge so the first fetch is on the bus.
   task automatic start();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_to_halt(output int cyc);
      cyc = 0;
      while (!halted && cyc < 400) begin
         @(posedge clk);
         #1;
         cyc = cyc + 1;
      end
      check_val("halt_reached", {63'd0, halted}, 64'd1);
   endtask

   int cyc;

   initial begin
      // ---- reset values and first fetch ----
      rst_n = 1'b0;
      delay = 8'd0;
      load_prog1();
      @(negedge clk);
      @(negedge clk);
      check_val("reset_outs",
                {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, halted, pc_dbg, acc_dbg, flags_dbg},
                64'd0);
      rst_n = 1'b1;
      #1;
      check_val("idle_req", {63'd0, bus.mem_req}, 64'd0);
      @(posedge clk);
      #1;
      check_val("first_fetch", {bus.mem_req, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 8'h00});
      run_to_halt(cyc);

      // ---- program 1, zero wait ----
      delay = 8'd0;
      load_prog1();
      start();
      run_to_halt(cyc);
      check_val("p1_cycles", cyc, 64'd8);
      check_val("p1_store", mem[8'h12], 64'h8000);
      check_val("p1_acc", acc_dbg, 64'h8000);
      check_val("p1_flags", flags_dbg, 64'b0101);
      check_val("p1_pc", pc_dbg, 64'h04);
      repeat (3) @(negedge clk);
      check_val("p1_req_after_halt", {bus.mem_req, halted}, {1'b0, 1'b1});

      // ---- program 1, three wait states per access ----
      delay = 8'd3;
      load_prog1();
      start();
      run_to_halt(cyc);
      check_val("p1w_cycles", cyc, 64'd29);
      check_val("p1w_store", mem[8'h12], 64'h8000);
      check_val("p1w_flags", flags_dbg, 64'b0101);
      check_val("p1w_pc", pc_dbg, 64'h04);
      check_val("p1w_waits", waits, 64'd21);
      check_val("p1w_hold", hold_viol, 64'd0);

      // ---- SUB to zero then JZ ----
      delay = 8'd0;
      clear_mem();
      mem[8'h00] = ins(4'h1, 8'h20);
      mem[8'h01] = ins(4'h4, 8'h20);
      mem[8'h02] = ins(4'hC, 8'h40);
      mem[8'h03] = ins(4'hF, 8'h00);
      mem[8'h40] = ins(4'hF, 8'h00);
      mem[8'h20] = 16'h0005;
      start();
      run_to_halt(cyc);
      check_val("jz_acc", acc_dbg, 64'h0000);
      check_val("jz_flags", flags_dbg, 64'b1010);
      check_val("jz_fetch_addr", rd_log[5], 64'h40);
      check_val("jz_pc", pc_dbg, 64'h41);

      // ---- PC wrap 0xFF -> 0x00 ----
      delay = 8'd1;
      clear_mem();
      mem[8'h00] = ins(4'hB, 8'hFE);
      mem[8'h01] = ins(4'hF, 8'h00);
      mem[8'hFE] = ins(4'h1, 8'h80);
      mem[8'hFF] = ins(4'h0, 8'h00);
      mem[8'h80] = 16'h8000;
      start();
      run_to_halt(cyc);
      check_val("wrap_prev_fetch", rd_log[3], 64'hFF);
      check_val("wrap_fetch", rd_log[4], 64'h00);
      check_val("wrap_reads", rd_n, 64'd6);
      check_val("wrap_state", {pc_dbg, acc_dbg, flags_dbg}, {8'h02, 16'h8000, 4'b0100});

      // ---- logic, shift, NOT, ADD carry, SUB borrow ----
      delay = 8'd0;
      clear_mem();
      mem[8'h00] = ins(4'h1, 8'h20);
      mem[8'h01] = ins(4'h5, 8'h21);
      mem[8'h02] = ins(4'h6, 8'h22);
      mem[8'h03] = ins(4'h9, 8'h00);
      mem[8'h04] = ins(4'h2, 8'h25);
      mem[8'h05] = ins(4'h8, 8'h00);
      mem[8'h06] = ins(4'h7, 8'h00);
      mem[8'h07] = ins(4'h3, 8'h23);
      mem[8'h08] = ins(4'h2, 8'h24);
      mem[8'h09] = ins(4'h4, 8'h21);
      mem[8'h0A] = ins(4'hF, 8'h00);
      mem[8'h20] = 16'h00F0;
      mem[8'h21] = 16'h0F3C;
      mem[8'h22] = 16'h8001;
      mem[8'h23] = 16'h0032;
      mem[8'h24] = 16'hFFFF;
      start();
      run_to_halt(cyc);
      check_val("alu_shl_store", mem[8'h25], 64'h0062);
      check_val("alu_add_store", mem[8'h24], 64'h0000);
      check_val("alu_acc", acc_dbg, 64'hF0C4);
      check_val("alu_flags", flags_dbg, 64'b0100);
      check_val("alu_pc", pc_dbg, 64'h0B);

      // ---- reset while waiting for a data ack ----
      delay = 8'd3;
      load_prog1();
      start();
      begin
         int guard;
         guard = 0;
         while (!(bus.mem_req && bus.mem_addr == 8'h10 && !bus.mem_ack) && guard < 100) begin
            @(negedge clk);
            guard = guard + 1;
         end
         check_val("mid_wait_seen", {bus.mem_req, bus.mem_addr}, {1'b1, 8'h10});
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_val("mid_reset_outs",
                {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, halted, pc_dbg, acc_dbg, flags_dbg},
                64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
